// File: rtl/fifo_wptr_ctrl_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// Binary/Gray conversions work on a fixed maximum pointer width. Callers
// zero-extend their pointers and cast the result back to their own width.
// Zero upper bits convert to zero upper bits in both directions, so the
// truncated result matches a conversion done at the narrower width.
package fifo_wptr_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int PTR_W          = ADDR_WIDTH_DEF + 1;
    localparam int MAX_PTR_W      = 13;

    function automatic logic [MAX_PTR_W-1:0] b2g(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] g2b(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-bit flop chain that brings a Gray-coded pointer into the local
// clock domain. Only one bit of the input changes at a time, so every
// sampled value is either the old pointer or the new one.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the pointer through the synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO.
// The controller keeps the binary and Gray write pointers and synchronizes
// the read Gray pointer. From these it derives full, fill level, almost
// full and a sticky overflow flag. The level uses a stale read pointer, so
// it can over-state occupancy but never over-states free space.
module fifo_wptr_ctrl
    import fifo_wptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  clr_ovf,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int                    PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH-1:0]  AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);

    logic [PTR_WIDTH-1:0] wbin_r;
    logic [PTR_WIDTH-1:0] wptr_gray_r;
    logic                 overflow_r;
    logic [PTR_WIDTH-1:0] wbin_next_s;
    logic [PTR_WIDTH-1:0] wgray_next_s;
    logic [PTR_WIDTH-1:0] rq_s;
    logic [PTR_WIDTH-1:0] rbin_s;
    logic [PTR_WIDTH-1:0] full_cmp_s;
    logic [PTR_WIDTH-1:0] level_s;
    logic                 full_s;
    logic                 accept_s;

    // Bring the read-domain Gray pointer into the write clock domain.
    gray_ptr_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rptr_gray_async),
        .q     (rq_s)
    );

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that is both top bits inverted. Only registers
    // feed this compare, so wr_req has no glitch path into full.
    assign full_cmp_s   = {~rq_s[PTR_WIDTH-1:PTR_WIDTH-2], rq_s[PTR_WIDTH-3:0]};
    assign full_s       = (wptr_gray_r == full_cmp_s);
    assign accept_s     = wr_req & ~full_s;
    assign wbin_next_s  = wbin_r + PTR_ONE;
    assign wgray_next_s = PTR_WIDTH'(b2g(MAX_PTR_W'(wbin_next_s)));
    assign rbin_s       = PTR_WIDTH'(g2b(MAX_PTR_W'(rq_s)));
    assign level_s      = wbin_r - rbin_s;

    // Advance both write pointers on every accepted write. The Gray form is
    // registered directly, so only one bit changes per accept as the read
    // domain sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_r      <= {PTR_WIDTH{1'b0}};
            wptr_gray_r <= {PTR_WIDTH{1'b0}};
        end else if (accept_s) begin
            wbin_r      <= wbin_next_s;
            wptr_gray_r <= wgray_next_s;
        end else begin
            wbin_r      <= wbin_r;
            wptr_gray_r <= wptr_gray_r;
        end
    end

    // Sticky overflow. A write attempt while full wins over a clear in the
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (wr_req && full_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign wr_en       = accept_s;
    assign waddr       = wbin_r[ADDR_WIDTH-1:0];
    assign wptr_gray   = wptr_gray_r;
    assign full        = full_s;
    assign wr_level    = level_s;
    assign almost_full = (level_s >= AFULL_LVL);
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed and randomized bench for fifo_wptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
// A reference model predicts the outputs that follow each clock edge.
// Each prediction is queued when the stimulus is driven, then popped and
// compared after the edge.
module tb_fifo_wptr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       clr_ovf;
    logic [4:0] rptr_gray_async;
    logic       wr_en;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    fifo_wptr_ctrl #(
        .ADDR_WIDTH   (4),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_req          (wr_req),
        .clr_ovf         (clr_ovf),
        .rptr_gray_async (rptr_gray_async),
        .wr_en           (wr_en),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .wr_level        (wr_level),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] gray;
        logic       full;
        logic [4:0] level;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [4:0] m_wbin;
    logic [4:0] m_s1;
    logic [4:0] m_s2;
    logic       m_ovf;
    logic [4:0] m_rtrue;

    function automatic logic [4:0] tb_b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] tb_g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin  = 5'd0;
        m_s1    = 5'd0;
        m_s2    = 5'd0;
        m_ovf   = 1'b0;
        m_rtrue = 5'd0;
        sb.delete();
    endtask

    // One clock cycle. Inputs are driven 1 time unit after a rising edge.
    // Combinational outputs are checked mid-cycle. Registered outputs are
    // checked 1 time unit after the next rising edge.
    task automatic step(input logic req, input logic clr, input logic [4:0] rg);
        logic [4:0] lvl;
        logic [4:0] occ;
        logic [4:0] prev_gray;
        logic       mfull;
        logic       acc;
        exp_t       e;
        exp_t       got;
        wr_req = req;
        clr_ovf = clr;
        rptr_gray_async = rg;
        #3;
        lvl   = m_wbin - tb_g2b(m_s2);
        mfull = (lvl == 5'd16);
        acc   = req & ~mfull;
        check("wr_en", wr_en, acc);
        check("waddr", waddr, m_wbin[3:0]);
        prev_gray = wptr_gray;
        if (acc) m_wbin = m_wbin + 5'd1;
        if (req && mfull) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_s2 = m_s1;
        m_s1 = rg;
        e.gray  = tb_b2g(m_wbin);
        e.level = m_wbin - tb_g2b(m_s2);
        e.full  = (e.level == 5'd16);
        e.af    = (e.level >= 5'd12);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("wptr_gray", wptr_gray, got.gray);
        check("full", full, got.full);
        check("wr_level", wr_level, got.level);
        check("almost_full", almost_full, got.af);
        check("overflow", overflow, got.ovf);
        check("gray_one_bit", $countones(prev_gray ^ wptr_gray), acc ? 32'd1 : 32'd0);
        occ = m_wbin - tb_g2b(rg);
        check("level_ge_occ", (wr_level >= occ) ? 32'd1 : 32'd0, 32'd1);
        if (occ == 5'd16) check("full_at_true_full", full, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_req = 1'b0;
        clr_ovf = 1'b0;
        rptr_gray_async = 5'd0;
        model_reset();
        #2;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_waddr", waddr, 4'd0);
        check("rst_wptr_gray", wptr_gray, 5'd0);
        check("rst_full", full, 1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_wr_level", wr_level, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill from empty with the read pointer held at zero.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 5'b00000);
        check("t1_full", full, 1'b1);
        check("t1_level", wr_level, 5'd16);
        check("t1_af", almost_full, 1'b1);

        // Write attempts while full set the sticky overflow flag.
        step(1'b1, 1'b0, 5'b00000);
        check("t2_ovf_set", overflow, 1'b1);
        check("t2_waddr_hold", waddr, 4'd0);
        step(1'b0, 1'b0, 5'b00000);
        check("t2_ovf_sticky", overflow, 1'b1);
        step(1'b0, 1'b1, 5'b00000);
        check("t2_ovf_clear", overflow, 1'b0);
        step(1'b1, 1'b1, 5'b00000);
        check("t2_set_wins", overflow, 1'b1);

        // One read: full releases two edges after the pointer changes.
        step(1'b0, 1'b0, 5'b00001);
        check("t3_full_edgeE", full, 1'b1);
        step(1'b0, 1'b0, 5'b00001);
        check("t3_full_release", full, 1'b0);
        check("t3_level15", wr_level, 5'd15);
        step(1'b0, 1'b0, 5'b00001);

        // Reader catches up to 16, then the writer wraps past 31 to 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'b11000);
        check("t4_empty", wr_level, 5'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 5'b11000);
        check("t4_wrap_gray", wptr_gray, 5'b00000);
        check("t4_wrap_full", full, 1'b1);

        // Drain, write seven entries, then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'b00000);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 5'b00000);
        check("t5_pre_waddr", waddr, 4'd7);
        #2;
        wr_req = 1'b0;
        rptr_gray_async = 5'd0;
        rst_n = 1'b0;
        #1;
        check("t5_wr_en", wr_en, 1'b0);
        check("t5_waddr", waddr, 4'd0);
        check("t5_wptr_gray", wptr_gray, 5'd0);
        check("t5_full", full, 1'b0);
        check("t5_af", almost_full, 1'b0);
        check("t5_level", wr_level, 5'd0);
        check("t5_ovf", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 5'b00000);
        check("t5_first_gray", wptr_gray, 5'b00001);

        // Random writes against random single-step read-pointer advances.
        m_rtrue = 5'd0;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] occ_now;
            logic       req;
            logic       clr;
            occ_now = m_wbin - m_rtrue;
            if (occ_now != 5'd0 && $urandom_range(0, 1) == 1) m_rtrue = m_rtrue + 5'd1;
            req = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(req, clr, tb_b2g(m_rtrue));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
